speicher_steuerung: RTL
=======================

Name: speicher_steuerung

Overview:
- Initiator-side memory controller. Accepts single-word read/write requests from the processor core and drives the strobe/acknowledge protocol of the single-port word RAM (LesenAn/SchreibenAn out; DatenBereit/DatenGeschrieben back).
- Issues exactly one one-cycle strobe per request, waits for the matching acknowledge with a timeout, and returns data, completion or error to the core.
- Sits between the core's load/store stage and the RAM.

Parameters:
- WORDSIZE, 32, data and address width in bits on both sides.
- WORDS, 32, number of RAM words; addresses >= WORDS are rejected without a RAM access.
- TIMEOUT, 15, cycles spent in WARTEN without an acknowledge before the request is aborted.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- CpuAnfrage  in  1  request valid; accepted when CpuBereit=1 at the rising edge.
- CpuSchreiben  in  1  1=write, 0=read; sampled with CpuAnfrage.
- CpuAdresse  in  WORDSIZE  word address.
- CpuDatenRein  in  WORDSIZE  write data.
- CpuBereit  out  1  controller idle, request can be accepted.
- CpuDatenRaus  out  WORDSIZE  read data; valid when CpuFertig=1; holds its value until the next successful read.
- CpuFertig  out  1  one-cycle pulse, request completed successfully.
- CpuFehler  out  1  one-cycle pulse, request aborted (address out of range or timeout).
- RamLesenAn  out  1  read strobe to RAM.
- RamSchreibenAn  out  1  write strobe to RAM.
- RamAdresse  out  WORDSIZE  address to RAM; held from acceptance until return to IDLE.
- RamDatenRein  out  WORDSIZE  write data to RAM; held like RamAdresse.
- RamDatenRaus  in  WORDSIZE  read data from RAM.
- RamDatenBereit  in  1  RAM read acknowledge.
- RamDatenGeschrieben  in  1  RAM write acknowledge.

Behaviour:
- All outputs are registered. Reset values: CpuBereit=1; all other outputs 0. Reset takes effect immediately; strobes drop asynchronously and state goes to IDLE.
- States: IDLE, AUSGABE, WARTEN, FEHLER.
- IDLE: CpuBereit=1.
  - If CpuAnfrage=1 and CpuAdresse < WORDS: latch CpuSchreiben, CpuAdresse and CpuDatenRein; set RamAdresse/RamDatenRein; set exactly one of RamLesenAn or RamSchreibenAn; CpuBereit->0; go to AUSGABE.
  - If CpuAnfrage=1 and CpuAdresse >= WORDS: CpuBereit->0; go to FEHLER. No strobe is issued.
- AUSGABE: the strobe is high for exactly this one cycle. At the next edge the strobe clears and state goes to WARTEN with the wait counter at 0. A strobe is never high for two consecutive cycles, because the RAM re-executes the access on every cycle its strobe is high.
- WARTEN:
  - Only the acknowledge matching the latched direction is honoured: RamDatenBereit for reads, RamDatenGeschrieben for writes. The other acknowledge is ignored.
  - On the matching ack: a read captures RamDatenRaus into CpuDatenRaus. CpuFertig->1 and CpuBereit->1 for one cycle; go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no ack: CpuFehler->1 and CpuBereit->1; go to IDLE. CpuDatenRaus is unchanged.
- FEHLER: CpuFehler pulses for one cycle, CpuBereit->1; go to IDLE.
- Latency for a normally behaving RAM:
  - Edge E0: request accepted.
  - E1: RAM samples the strobe; the strobe clears.
  - E2: ack seen.
  - CpuFertig is high in the cycle after E2; round trip is 2 edges.
- Back-to-back: a request presented while CpuFertig or CpuFehler is high is accepted at that edge, because CpuBereit is also high.
- CpuAnfrage while CpuBereit=0 is ignored, not queued; the core must hold it.
- Acks arriving in IDLE, AUSGABE or FEHLER are ignored. This covers stale acks after a reset mid-operation.
- Counter width is clog2(TIMEOUT)+1 bits and saturates; it never wraps.
- Address compare is unsigned, full WORDSIZE width.

Decomposition:
- Shared package speicher_pkg:
  - state encoding constants (IDLE=0, AUSGABE=1, WARTEN=2, FEHLER=3);
  - the default TIMEOUT constant;
  - the ZUGRIFF_LESEN/ZUGRIFF_SCHREIBEN direction constants.
- One sub-module, warte_zaehler: clear/enable/saturating counter with a terminal-count output. The FSM stays in the top module.

Test Plan:
- Write 0xDEADBEEF to address 5, then read address 5 -> exactly one RamSchreibenAn cycle, CpuFertig 2 edges after acceptance; read returns CpuDatenRaus=0xDEADBEEF, exactly one RamLesenAn cycle.
- Read address 32 with WORDS=32 -> no RAM strobe, CpuFehler one cycle, CpuBereit=1 the next cycle, CpuDatenRaus unchanged.
- RAM model that never acks -> CpuFehler pulse exactly TIMEOUT cycles after entering WARTEN; a following valid read to address 3 completes normally.
- Read request while the bench injects RamDatenGeschrieben=1 only -> ignored, timeout taken. Spurious RamDatenBereit in IDLE -> no CpuFertig.
- CpuAnfrage held high for 4 back-to-back reads to addresses 0..3 -> new accept on each CpuFertig edge, one strobe per request, results in order.
- Reset_n low during AUSGABE -> RamLesenAn=0 immediately, CpuBereit=1. After release, a stale RamDatenBereit produces no CpuFertig, and a new write completes.

Source files
------------

// File: rtl/speicher_pkg.sv
// Shared types and constants for the memory controller.
// Imported by the controller top and its wait counter.
package speicher_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      AUSGABE = 2'd1,
      WARTEN  = 2'd2,
      FEHLER  = 2'd3
   } zustand_t;

   localparam int TIMEOUT_STD = 15;

   localparam logic ZUGRIFF_LESEN     = 1'b0;
   localparam logic ZUGRIFF_SCHREIBEN = 1'b1;

endpackage

// File: rtl/speicher_steuerung_warte_zaehler.sv
// Clear/enable counter that stops at ENDE-1 and flags that value.
// Used to bound the wait for a RAM acknowledge.
module warte_zaehler #(
   parameter int ENDE   = 15,
   parameter int BREITE = $clog2(ENDE) + 1
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic loeschen_i,
   input  logic zaehlen_i,
   output logic ende_o
);

   localparam logic [BREITE-1:0] LETZTER = BREITE'(ENDE - 1);

   logic [BREITE-1:0] stand_q, stand_d;

   always_comb begin
      stand_d = stand_q;
      if (loeschen_i) begin
         stand_d = '0;
      end else if (zaehlen_i && (stand_q != LETZTER)) begin
         stand_d = stand_q + BREITE'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         stand_q <= '0;
      end else begin
         stand_q <= stand_d;
      end
   end

   assign ende_o = (stand_q == LETZTER);

endmodule

// File: rtl/speicher_steuerung.sv
// Initiator-side controller for the single-port word RAM:
// one strobe per request, acknowledge wait with timeout.
module speicher_steuerung
   import speicher_pkg::*;
#(
   parameter int WORDSIZE = 32,
   parameter int WORDS    = 32,
   parameter int TIMEOUT  = TIMEOUT_STD
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                CpuAnfrage,
   input  logic                CpuSchreiben,
   input  logic [WORDSIZE-1:0] CpuAdresse,
   input  logic [WORDSIZE-1:0] CpuDatenRein,
   output logic                CpuBereit,
   output logic [WORDSIZE-1:0] CpuDatenRaus,
   output logic                CpuFertig,
   output logic                CpuFehler,
   output logic                RamLesenAn,
   output logic                RamSchreibenAn,
   output logic [WORDSIZE-1:0] RamAdresse,
   output logic [WORDSIZE-1:0] RamDatenRein,
   input  logic [WORDSIZE-1:0] RamDatenRaus,
   input  logic                RamDatenBereit,
   input  logic                RamDatenGeschrieben
);

   localparam logic [WORDSIZE-1:0] ADR_GRENZE = WORDSIZE'(WORDS);

   zustand_t            state_q, state_d;
   logic                richt_q, richt_d;
   logic                bereit_q, bereit_d;
   logic                fertig_q, fertig_d;
   logic                fehler_q, fehler_d;
   logic                lesen_q, lesen_d;
   logic                schreiben_q, schreiben_d;
   logic [WORDSIZE-1:0] adr_q, adr_d;
   logic [WORDSIZE-1:0] wdat_q, wdat_d;
   logic [WORDSIZE-1:0] rdat_q, rdat_d;

   logic z_loeschen, z_zaehlen, z_ende;
   logic ack_passt;

   warte_zaehler #(
      .ENDE (TIMEOUT)
   ) u_zaehler (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .loeschen_i (z_loeschen),
      .zaehlen_i  (z_zaehlen),
      .ende_o     (z_ende)
   );

   // Only the acknowledge of the latched direction counts.
   assign ack_passt = (richt_q == ZUGRIFF_LESEN) ?
                      RamDatenBereit : RamDatenGeschrieben;

   always_comb begin
      state_d     = state_q;
      richt_d     = richt_q;
      bereit_d    = bereit_q;
      fertig_d    = 1'b0;
      fehler_d    = 1'b0;
      lesen_d     = 1'b0;
      schreiben_d = 1'b0;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      rdat_d      = rdat_q;
      z_loeschen  = 1'b0;
      z_zaehlen   = 1'b0;

      unique case (state_q)
         IDLE: begin
            bereit_d = 1'b1;
            if (CpuAnfrage) begin
               bereit_d = 1'b0;
               if (CpuAdresse < ADR_GRENZE) begin
                  richt_d     = CpuSchreiben;
                  adr_d       = CpuAdresse;
                  wdat_d      = CpuDatenRein;
                  lesen_d     = (CpuSchreiben == ZUGRIFF_LESEN);
                  schreiben_d = (CpuSchreiben == ZUGRIFF_SCHREIBEN);
                  state_d     = AUSGABE;
               end else begin
                  state_d = FEHLER;
               end
            end
         end
         AUSGABE: begin
            z_loeschen = 1'b1;
            state_d    = WARTEN;
         end
         WARTEN: begin
            if (ack_passt) begin
               if (richt_q == ZUGRIFF_LESEN) begin
                  rdat_d = RamDatenRaus;
               end
               fertig_d = 1'b1;
               bereit_d = 1'b1;
               state_d  = IDLE;
            end else if (z_ende) begin
               fehler_d = 1'b1;
               bereit_d = 1'b1;
               state_d  = IDLE;
            end else begin
               z_zaehlen = 1'b1;
            end
         end
         FEHLER: begin
            fehler_d = 1'b1;
            bereit_d = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            bereit_d = 1'b1;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         richt_q     <= ZUGRIFF_LESEN;
         bereit_q    <= 1'b1;
         fertig_q    <= 1'b0;
         fehler_q    <= 1'b0;
         lesen_q     <= 1'b0;
         schreiben_q <= 1'b0;
         adr_q       <= '0;
         wdat_q      <= '0;
         rdat_q      <= '0;
      end else begin
         state_q     <= state_d;
         richt_q     <= richt_d;
         bereit_q    <= bereit_d;
         fertig_q    <= fertig_d;
         fehler_q    <= fehler_d;
         lesen_q     <= lesen_d;
         schreiben_q <= schreiben_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
         rdat_q      <= rdat_d;
      end
   end

   assign CpuBereit      = bereit_q;
   assign CpuDatenRaus   = rdat_q;
   assign CpuFertig      = fertig_q;
   assign CpuFehler      = fehler_q;
   assign RamLesenAn     = lesen_q;
   assign RamSchreibenAn = schreiben_q;
   assign RamAdresse     = adr_q;
   assign RamDatenRein   = wdat_q;

endmodule
